// File: rtl/lfsr_rng_sched.sv
//------------------------------------------------------------------------------
// Module   : lfsr_rng_sched
// Purpose  : Round-robin scheduler sharing one Galois LFSR among NREQ
//            requesters. A granted request advances the LFSR by STEPS shifts
//            and then presents the resulting word over a valid/ready
//            handshake, tagged with the requester index.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            req[NREQ]       - per-requester level request (sampled in IDLE)
//            seed_load, seed - reseed the LFSR (IDLE only, 0 maps to all ones)
//            out_valid/out_ready/out_data/out_id - word delivery handshake
//            gnt[NREQ]       - one-hot decode of out_valid by out_id
//            busy            - high while stepping or delivering
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_rng_sched #(
  parameter int               NREQ   = 4,
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 16'h001D,
  parameter int               STEPS  = 16,
  parameter bit               INVERT = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic                     seed_load,
  input  logic [WIDTH-1:0]         seed,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STEP    = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [WIDTH-1:0]  r_lfsr;
  logic [WIDTH-1:0]  w_lfsr_step;
  logic              w_fb;
  logic [CNT_W-1:0]  r_cnt;
  logic [ID_W-1:0]   r_id;        // requester owning the current transaction
  logic [ID_W-1:0]   r_last;      // last requester served (round-robin pointer)
  logic [WIDTH-1:0]  r_data_hold; // last delivered word, shown outside DELIVER
  logic [ID_W-1:0]   r_id_hold;   // last delivered id, shown outside DELIVER

  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_idx;

  // One Galois shift.
  assign w_fb        = r_lfsr[WIDTH-1] ^ INVERT;
  assign w_lfsr_step = {r_lfsr[WIDTH-2:0], 1'b0} ^ (w_fb ? TAPS : '0);

  // Round-robin search starting just after the last served requester.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = ID_W'((int'(r_last) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and outputs.
  always_comb begin
    w_next_state = r_state;
    out_valid    = 1'b0;
    busy         = 1'b0;
    out_data     = r_data_hold;
    out_id       = r_id_hold;
    case (r_state)
      S_IDLE: begin
        // Reseeding takes precedence over starting a grant.
        if (!seed_load && w_found) begin
          w_next_state = S_STEP;
        end
      end
      S_STEP: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = S_DELIVER;
        end
      end
      S_DELIVER: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_lfsr;
        out_id    = r_id;
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign gnt = NREQ'(out_valid) << r_id;

  // Datapath: LFSR, step counter, arbitration pointer and delivery holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr      <= '1;
      r_cnt       <= '0;
      r_id        <= '0;
      r_last      <= ID_W'(NREQ - 1);
      r_data_hold <= '0;
      r_id_hold   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (seed_load) begin
            // An all-zero seed would lock the LFSR, so substitute all ones.
            r_lfsr <= (seed == '0) ? '1 : seed;
          end else if (w_found) begin
            r_id  <= w_win;
            r_cnt <= CNT_W'(STEPS - 1);
          end
        end
        S_STEP: begin
          r_lfsr <= w_lfsr_step;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DELIVER: begin
          if (out_ready) begin
            r_last      <= r_id;
            r_data_hold <= r_lfsr;
            r_id_hold   <= r_id;
          end
        end
        default: begin
          r_lfsr <= r_lfsr;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
